// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_addr_decoder
// Description : AHB-Lite region decoder, data-phase response mux and built-in
//               default slave that answers unmapped transfers with ERROR.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module ahb_addr_decoder #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [CNT_W-1:0]             err_count
);

  localparam logic [SEL_W-1:0] C_NUM_SLAVES = SEL_W'(NUM_SLAVES);

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t          state_q, state_d;
  logic [SEL_W-1:0]   dsel_q;
  logic               dvalid_q;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic [SEL_W-1:0]   w_region;
  logic               w_mapped;
  logic               w_err_start;
  logic [DATA_W-1:0]  w_slv_rdata;
  logic               w_slv_ready;
  logic               w_slv_resp;
  logic               w_unused_bits;

  assign w_region      = HADDR[ADDR_W-1 -: SEL_W];
  assign w_mapped      = (w_region < C_NUM_SLAVES);
  assign w_unused_bits = ^{HADDR[ADDR_W-SEL_W-1:0], HTRANS[0]};

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hsel
      assign HSEL[gi] = (w_region == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    w_slv_rdata = '0;
    w_slv_ready = 1'b1;
    w_slv_resp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == SEL_W'(i)) begin
        w_slv_rdata = HRDATA_S[i*DATA_W +: DATA_W];
        w_slv_ready = HREADYOUT_S[i];
        w_slv_resp  = HRESP_S[i];
      end
    end
  end

  // Unmapped data phases are answered by the default slave, never a real slave.
  always_comb begin
    HRDATA = '0;
    HREADY = (state_q != DS_ERR1);
    HRESP  = (state_q != DS_OK);
    if (dvalid_q) begin
      HRDATA = w_slv_rdata;
      HREADY = w_slv_ready;
      HRESP  = w_slv_resp;
    end
  end

  assign w_err_start = HREADY && HTRANS[1] && !w_mapped;

  always_comb begin
    state_d     = state_q;
    err_count_d = err_count_q;
    case (state_q)
      DS_OK:   if (w_err_start) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = w_err_start ? DS_ERR1 : DS_OK;
      default: state_d = DS_OK;
    endcase
    if ((state_d == DS_ERR1) && (state_q != DS_ERR1) && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= DS_OK;
      dsel_q      <= '0;
      dvalid_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (HREADY) begin
        dsel_q   <= w_region;
        dvalid_q <= w_mapped;
      end
      state_q     <= state_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

endmodule
`default_nettype wire
